instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter WIDTH_MAIN, default 8, main/mem bus width in bits.
REQ-002 SHALL have parameter WIDTH_AX, default 16, operand width in bits (2 x WIDTH_MAIN).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begin fetching from IDLE.
REQ-006 SHALL have port halt, input, 1, return to IDLE after the current handshake.
REQ-007 SHALL have port mem_in, input, WIDTH_MAIN, mem bus data at the current address.
REQ-008 SHALL have port pc_assert_addr, output, 1, drives the PC register's assert_addr.
REQ-009 SHALL have port pc_inc, output, 1, drives the PC register's inc.
REQ-010 SHALL have port mem_busdir, output, 1, drives memory bus_dir (high = mem->main).
REQ-011 SHALL have ports opcode (WIDTH_MAIN), operand (WIDTH_AX) and op_len (2), outputs, the fetched instruction.
REQ-012 SHALL have ports instr_valid (output, 1) and instr_ready (input, 1), the downstream handshake.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port instr_count, output, 16, retired-instruction count (see Configuration).

Function
REQ-015 SHALL implement states IDLE, FETCH_OP, FETCH_B1, FETCH_B2, PRESENT.
REQ-016 IDLE: start=1 -> FETCH_OP; start in any other state SHALL be ignored.
REQ-017 In FETCH_OP/FETCH_B1/FETCH_B2, pc_assert_addr, mem_busdir and pc_inc SHALL all be 1; all three SHALL be 0 in IDLE and PRESENT; they are Moore outputs decoded from the state register only.
REQ-018 FETCH_OP SHALL latch mem_in into opcode, clear operand to 0, and set op_len = opcode[7:6] saturated to 2 (00->0, 01->1, 10/11->2).
REQ-019 FETCH_OP next state: op_len 0 -> PRESENT, otherwise -> FETCH_B1.
REQ-020 FETCH_B1 SHALL latch mem_in into operand[7:0]; next state is FETCH_B2 if op_len=2, else PRESENT.
REQ-021 FETCH_B2 SHALL latch mem_in into operand[15:8] (little-endian); next state is PRESENT.
REQ-022 Exactly one pc_inc cycle SHALL occur per byte fetched (1 + op_len per instruction).
REQ-023 PRESENT: instr_valid=1; opcode/operand/op_len SHALL remain stable until the handshake.
REQ-024 Handshake = instr_valid & instr_ready at a rising edge; then halt=1 -> IDLE, halt=0 -> FETCH_OP.
REQ-025 Latency: valid SHALL assert 1 + op_len cycles after leaving IDLE or after the prior handshake.
REQ-026 instr_ready while instr_valid=0 SHALL have no effect; halt outside PRESENT SHALL have no effect.

Reset
REQ-027 reset=1 SHALL immediately, without waiting for clk, force IDLE and set all outputs to 0, including opcode, operand, op_len and instr_count.
REQ-028 Reset during any FETCH state SHALL abort the fetch with no further pc_inc; the partially latched instruction is discarded.

Configuration
REQ-029 Macro INSTR_FETCH_COUNT_EN defined: instr_count SHALL increment by 1 per handshake, saturating at 0xFFFF.
REQ-030 Macro INSTR_FETCH_COUNT_EN undefined: instr_count SHALL be constant 0 and no counter flops SHALL exist; the port list is identical in both builds.

Verification
REQ-031 Mem 0x05 at PC, start pulse -> one FETCH cycle, one pc_inc; then valid with opcode=0x05, operand=0x0000, op_len=0.
REQ-032 Mem 0x41,0x7E -> two pc_inc cycles; then opcode=0x41, operand=0x007E, op_len=1, valid on the 3rd edge after start.
REQ-033 Mem 0x82,0x34,0x12 -> three pc_inc cycles; then operand=0x1234, op_len=2.
REQ-034 instr_ready held low 5 cycles in PRESENT -> valid held, outputs stable, pc_inc=0; ready=1 with halt=0 -> FETCH_OP on the next cycle; with halt=1 -> IDLE, busy=0.
REQ-035 reset asserted mid-FETCH_B1, between edges -> all outputs 0 before the next edge; state IDLE; no pc_inc afterwards.
REQ-036 Three completed handshakes -> instr_count=3 with INSTR_FETCH_COUNT_EN defined; 0 with it undefined.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: fetches opcode plus 0-2 little-endian operand bytes and presents them over valid/ready.
// Define INSTR_FETCH_COUNT_EN to enable the saturating retired-instruction counter on instr_count.
module instr_fetch #(
    parameter int WIDTH_MAIN = 8,
    parameter int WIDTH_AX = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt,
    input  logic [WIDTH_MAIN-1:0] mem_in,
    output logic                  pc_assert_addr,
    output logic                  pc_inc,
    output logic                  mem_busdir,
    output logic [WIDTH_MAIN-1:0] opcode,
    output logic [WIDTH_AX-1:0]   operand,
    output logic [1:0]            op_len,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  busy,
    output logic [15:0]           instr_count
);
    typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_B1, FETCH_B2, PRESENT} state_t;
    state_t state, state_nxt;
    logic [1:0] len_in;
    logic fetch, hs;
    // top two opcode bits give the operand length, 11 saturating to 2
    assign len_in = mem_in[WIDTH_MAIN-1] ? 2'd2 : {1'b0, mem_in[WIDTH_MAIN-2]};
    assign fetch = state == FETCH_OP || state == FETCH_B1 || state == FETCH_B2;
    assign hs = instr_valid && instr_ready;
    assign pc_assert_addr = fetch;
    assign pc_inc = fetch;
    assign mem_busdir = fetch;
    assign instr_valid = state == PRESENT;
    assign busy = state != IDLE;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = start ? FETCH_OP : IDLE;
            FETCH_OP: state_nxt = len_in == 2'd0 ? PRESENT : FETCH_B1;
            FETCH_B1: state_nxt = op_len == 2'd2 ? FETCH_B2 : PRESENT;
            FETCH_B2: state_nxt = PRESENT;
            PRESENT:  state_nxt = hs ? (halt ? IDLE : FETCH_OP) : PRESENT;
            default:  state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            opcode <= '0;
            operand <= '0;
            op_len <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH_OP) begin
                opcode <= mem_in;
                operand <= '0;
                op_len <= len_in;
            end
            if (state == FETCH_B1) operand[WIDTH_MAIN-1:0] <= mem_in;
            if (state == FETCH_B2) operand[WIDTH_AX-1:WIDTH_MAIN] <= mem_in;
        end
    end
`ifdef INSTR_FETCH_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) instr_count <= '0;
        else if (hs && instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
    end
`else
    assign instr_count = '0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random instruction stream through a memory/PC model, scoreboard-checked by a monitor.
module tb_instr_fetch;
    typedef struct {
        logic [7:0]  op;
        logic [15:0] opd;
        logic [1:0]  len;
    } instr_t;
    logic clk = 0, reset = 1, start = 0, halt = 0, instr_ready = 0;
    logic pc_assert_addr, pc_inc, mem_busdir, instr_valid, busy;
    logic [7:0] opcode, mem_in;
    logic [15:0] operand, instr_count;
    logic [1:0] op_len;
    logic [7:0] mem [256];
    logic [7:0] pc = 0;
    int wp = 0, tests = 0, fails = 0, hs = 0, cnt = 0, bytes = 0, incs = 0;
    logic pv = 0;
    logic [7:0] sv_op;
    logic [15:0] sv_opd;
    logic [1:0] sv_len;
    instr_t q[$];

    instr_fetch dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .mem_in(mem_in),
        .pc_assert_addr(pc_assert_addr), .pc_inc(pc_inc), .mem_busdir(mem_busdir),
        .opcode(opcode), .operand(operand), .op_len(op_len),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;
    assign mem_in = mem[pc];
    always @(posedge clk) if (pc_inc) pc <= pc + 8'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_count(input int n);
`ifdef INSTR_FETCH_COUNT_EN
        return n > 65535 ? 16'hFFFF : 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    task automatic load(input logic [7:0] op, input logic [15:0] opd);
        instr_t t;
        t.op = op;
        t.len = op[7:6] == 2'b00 ? 2'd0 : op[7:6] == 2'b01 ? 2'd1 : 2'd2;
        t.opd = t.len == 0 ? 16'h0 : t.len == 1 ? {8'h0, opd[7:0]} : opd;
        mem[8'(wp)] = op;
        for (int i = 0; i < t.len; i++) mem[8'(wp + 1 + i)] = i == 0 ? opd[7:0] : opd[15:8];
        wp += 1 + t.len;
        bytes += 1 + t.len;
        q.push_back(t);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            cnt = 0;
            pv = 0;
        end else begin
            if (pc_inc) begin
                cnt++;
                incs++;
            end
            chk("moore_outputs", {29'd0, pc_assert_addr, mem_busdir, pc_inc},
                busy && !instr_valid ? 32'd7 : 32'd0);
            if (instr_valid) begin
                if (!pv) begin
                    if (q.size() == 0) chk("unexpected_valid", 1, 0);
                    else begin
                        chk("opcode", opcode, q[0].op);
                        chk("operand", operand, q[0].opd);
                        chk("op_len", op_len, q[0].len);
                        chk("latency_pc_inc", cnt, 1 + q[0].len);
                    end
                end else begin
                    chk("hold_opcode", opcode, sv_op);
                    chk("hold_operand", operand, sv_opd);
                    chk("hold_op_len", op_len, sv_len);
                end
                sv_op = opcode;
                sv_opd = operand;
                sv_len = op_len;
                if (instr_ready) begin
                    chk("instr_count", instr_count, exp_count(hs));
                    if (q.size() > 0) void'(q.pop_front());
                    hs++;
                    cnt = 0;
                end
            end
            pv = instr_valid && !instr_ready;
        end
    end

    initial begin
        logic [7:0] p0;
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #1;
        chk("rst_outputs", {opcode, operand, op_len, pc_assert_addr, pc_inc, mem_busdir, instr_valid, busy},
            32'd0);
        chk("rst_count", instr_count, 0);
        load(8'h05, 16'h0);
        load(8'h41, 16'h007E);
        load(8'h82, 16'h1234);
        for (int i = 0; i < 40; i++) load(8'($urandom), 16'($urandom));
        repeat (2) @(posedge clk);
        #1 reset = 0;
        cyc = 0;
        while ((q.size() > 0 || busy) && cyc < 5000) begin
            start = q.size() > 0 && (!busy || $urandom_range(1) == 1);
            instr_ready = $urandom_range(3) != 0;
            halt = q.size() <= 1 || $urandom_range(7) == 0;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 5000) chk("run_timeout", cyc, 0);
        start = 0;
        instr_ready = 0;
        halt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_halt", busy, 0);
        chk("total_pc_inc", incs, bytes);
        chk("final_count", instr_count, exp_count(hs));
        wp = int'(pc);
        mem[pc] = 8'h82;
        mem[pc + 8'd1] = 8'h11;
        mem[pc + 8'd2] = 8'h22;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        @(posedge clk);
        #1;
        chk("in_fetch_b1", pc_inc, 1);
        #2 reset = 1;
        #1;
        chk("async_rst_outputs", {opcode, operand, op_len, pc_assert_addr, pc_inc, mem_busdir, instr_valid, busy},
            32'd0);
        chk("async_rst_count", instr_count, 0);
        p0 = pc;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_inc_after_rst", pc, p0);
        chk("idle_after_rst", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
